// File: rtl/anton_neopixel_multilane.sv
// anton_neopixel_multilane
// Multi-lane NeoPixel (WS2812-style) frame streamer. A byte-wide pixel
// buffer holds LANES independent banks. A frame request streams the first
// pixelCount pixels of every bank out in parallel, one lane per output bit.
// The lanes are bit-aligned. Each frame ends with a low latch period.
//
// Ports:
//   clk6_4mhz  - sole clock, rising edge
//   reset      - synchronous, active-high
//   wrEn       - buffer byte write strobe (accepted in any state)
//   wrAddr     - byte address = (lane*PIXELS + pixel)*CHANNELS + channel
//   wrData     - byte to write
//   start      - single-cycle frame request (ignored while busy)
//   loop       - when high at the end of a latch, start another frame
//   pixelCount - pixels per lane to send (clamped to PIXELS)
//   neoData    - encoded serial data, bit n drives lane n
//   busy       - high while a frame (load, data or latch) is in progress
//   frameDone  - one-cycle pulse on the last latch cycle
module anton_neopixel_multilane #(
    parameter int LANES       = 2,
    parameter int CHANNELS    = 3,
    parameter int PIXELS      = 64,
    parameter int PATTERN_LEN = 8,
    parameter int T0H         = 2,
    parameter int T1H         = 5,
    parameter int RESET_DELAY = 400,
    localparam int DEPTH      = LANES * PIXELS * CHANNELS,
    localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW         = $clog2(PIXELS + 1)
) (
    input  logic             clk6_4mhz,
    input  logic             reset,
    input  logic             wrEn,
    input  logic [AW-1:0]    wrAddr,
    input  logic [7:0]       wrData,
    input  logic             start,
    input  logic             loop,
    input  logic [CW-1:0]    pixelCount,
    output logic [LANES-1:0] neoData,
    output logic             busy,
    output logic             frameDone
);

    localparam int PW  = (PATTERN_LEN > 1) ? $clog2(PATTERN_LEN) : 1;
    localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int LW  = $clog2(RESET_DELAY + 1);

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, LATCH} stateT;

    stateT           state;
    logic [7:0]      mem [DEPTH];
    logic [7:0]      shiftReg [LANES];
    logic [PW-1:0]   phase;
    logic [2:0]      bitIdx;
    logic [CHW-1:0]  chanIdx;
    logic [CW-1:0]   pixelIdx;
    logic [CW-1:0]   countReg;
    logic [LW-1:0]   latchCnt;

    logic            lastChan;
    logic            lastByte;
    logic            slotEnd;
    logic [CHW-1:0]  nextChan;
    logic [CW-1:0]   nextPix;

    function automatic logic [AW-1:0] byteAddr(input int lane, input int pix, input int ch);
        return AW'((lane * PIXELS + pix) * CHANNELS + ch);
    endfunction

    function automatic logic [CW-1:0] clampCount(input logic [CW-1:0] req);
        return (int'(req) > PIXELS) ? CW'(PIXELS) : req;
    endfunction

    // Buffer writes are independent of the frame state machine and are never
    // cleared by reset. Addresses past the last byte are dropped.
    always_ff @(posedge clk6_4mhz) begin
        if (wrEn && (int'(wrAddr) < DEPTH)) begin
            mem[wrAddr] <= wrData;
        end
    end

    // Position of the byte that follows the one currently on the wire.
    always_comb begin
        lastChan = (int'(chanIdx) == CHANNELS - 1);
        nextChan = lastChan ? '0 : chanIdx + CHW'(1);
        nextPix  = lastChan ? pixelIdx + CW'(1) : pixelIdx;
        lastByte = lastChan && (int'(pixelIdx) == int'(countReg) - 1);
        slotEnd  = (int'(phase) == PATTERN_LEN - 1);
    end

    // Frame sequencer. neoData is registered one cycle ahead: on each edge it
    // takes the level for the phase about to start. The first cycle of every
    // slot is always high because T0H > 0. Each new byte is fetched on the
    // final cycle of the previous byte. A write to the same address in that
    // cycle therefore still delivers the old byte, and any earlier write is
    // picked up.
    always_ff @(posedge clk6_4mhz) begin
        if (reset) begin
            state     <= IDLE;
            neoData   <= '0;
            busy      <= 1'b0;
            frameDone <= 1'b0;
            phase     <= '0;
            bitIdx    <= '0;
            chanIdx   <= '0;
            pixelIdx  <= '0;
            countReg  <= '0;
            latchCnt  <= '0;
            for (int n = 0; n < LANES; n++) begin
                shiftReg[n] <= '0;
            end
        end else begin
            frameDone <= 1'b0;
            case (state)
                IDLE: begin
                    neoData <= '0;
                    if (start) begin
                        countReg <= clampCount(pixelCount);
                        state    <= LOAD;
                        busy     <= 1'b1;
                    end
                end

                LOAD: begin
                    for (int n = 0; n < LANES; n++) begin
                        shiftReg[n] <= mem[byteAddr(n, 0, 0)];
                    end
                    phase    <= '0;
                    bitIdx   <= '0;
                    chanIdx  <= '0;
                    pixelIdx <= '0;
                    latchCnt <= '0;
                    if (countReg == '0) begin
                        state     <= LATCH;
                        neoData   <= '0;
                        frameDone <= (RESET_DELAY == 1);
                    end else begin
                        state   <= STREAM;
                        neoData <= '1;
                    end
                end

                STREAM: begin
                    if (!slotEnd) begin
                        phase <= phase + PW'(1);
                        for (int n = 0; n < LANES; n++) begin
                            neoData[n] <= (int'(phase) + 1) < (shiftReg[n][7] ? T1H : T0H);
                        end
                    end else begin
                        phase <= '0;
                        if (bitIdx != 3'd7) begin
                            bitIdx  <= bitIdx + 3'd1;
                            neoData <= '1;
                            for (int n = 0; n < LANES; n++) begin
                                shiftReg[n] <= {shiftReg[n][6:0], 1'b0};
                            end
                        end else if (lastByte) begin
                            bitIdx    <= '0;
                            latchCnt  <= '0;
                            state     <= LATCH;
                            neoData   <= '0;
                            frameDone <= (RESET_DELAY == 1);
                        end else begin
                            bitIdx   <= '0;
                            chanIdx  <= nextChan;
                            pixelIdx <= nextPix;
                            neoData  <= '1;
                            for (int n = 0; n < LANES; n++) begin
                                shiftReg[n] <= mem[byteAddr(n, int'(nextPix), int'(nextChan))];
                            end
                        end
                    end
                end

                LATCH: begin
                    neoData <= '0;
                    if (int'(latchCnt) == RESET_DELAY - 1) begin
                        latchCnt <= '0;
                        if (loop) begin
                            countReg <= clampCount(pixelCount);
                            state    <= LOAD;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        latchCnt  <= latchCnt + LW'(1);
                        frameDone <= (int'(latchCnt) + 2 == RESET_DELAY);
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_anton_neopixel_multilane.sv
// tb_anton_neopixel_multilane
// Scoreboard bench for anton_neopixel_multilane. Two instances share clock
// and reset: dut0 is RGB (CHANNELS=3) and dut1 is RGBW (CHANNELS=4). Both
// use LANES=2 and PIXELS=4. Stimulus pushes the expected bytes and frame
// records into queues. A monitor decodes the serial lanes and frameDone
// pulses and pops the queues to compare them.
module tb_anton_neopixel_multilane;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic [1:0]      wrEn, start, loop, busyS, fdS;
    logic [1:0][4:0] wrAddr;
    logic [1:0][7:0] wrData;
    logic [1:0][2:0] pixelCount;
    logic [1:0][1:0] neo;

    anton_neopixel_multilane #(.LANES(2), .CHANNELS(3), .PIXELS(4)) dut0 (
        .clk6_4mhz(clk), .reset(reset), .wrEn(wrEn[0]), .wrAddr(wrAddr[0]),
        .wrData(wrData[0]), .start(start[0]), .loop(loop[0]),
        .pixelCount(pixelCount[0]), .neoData(neo[0]), .busy(busyS[0]),
        .frameDone(fdS[0]));

    anton_neopixel_multilane #(.LANES(2), .CHANNELS(4), .PIXELS(4)) dut1 (
        .clk6_4mhz(clk), .reset(reset), .wrEn(wrEn[1]), .wrAddr(wrAddr[1]),
        .wrData(wrData[1]), .start(start[1]), .loop(loop[1]),
        .pixelCount(pixelCount[1]), .neoData(neo[1]), .busy(busyS[1]),
        .frameDone(fdS[1]));

    typedef struct packed {int bits; int len;} frameT;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] model [2][2][4][4];
    logic [7:0] byteQ [4][$];
    frameT      frameQ [2][$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int chOf(input int u);
        return (u == 0) ? 3 : 4;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitor state, one entry per instance and lane
    logic       prevV [2][2];
    int         highCnt [2][2];
    int         nbits [2][2];
    int         lastRise [2][2];
    logic [7:0] acc [2][2];
    logic       prevBusy [2];
    int         frameStart [2];
    frameT      fr;
    logic [7:0] expB;

    // Decode the lanes on the falling edge. Each pulse's high time selects
    // the bit value. Every 8 bits form a byte, which is checked against the
    // queue. frameDone pops a frame record and compares the per-lane bit
    // counts and the frame length.
    always @(negedge clk) begin
        if (reset) begin
            for (int u = 0; u < 2; u++) begin
                prevBusy[u] = 1'b0;
                for (int l = 0; l < 2; l++) begin
                    prevV[u][l] = 1'b0; highCnt[u][l] = 0; nbits[u][l] = 0;
                    acc[u][l] = '0; lastRise[u][l] = -100;
                end
            end
        end else begin
            for (int u = 0; u < 2; u++) begin
                if (busyS[u] && !prevBusy[u]) frameStart[u] = cyc;
                prevBusy[u] = busyS[u];
                for (int l = 0; l < 2; l++) begin
                    if (neo[u][l] && !prevV[u][l]) begin
                        if (l == 1) checkOutput($sformatf("lane align dut%0d", u), lastRise[u][0], cyc);
                        if (nbits[u][l] > 0) checkOutput($sformatf("slot period dut%0d lane%0d", u, l), cyc - lastRise[u][l], 8);
                        lastRise[u][l] = cyc;
                        highCnt[u][l] = 1;
                    end else if (neo[u][l]) begin
                        highCnt[u][l]++;
                    end
                    if (!neo[u][l] && prevV[u][l]) begin
                        checks++;
                        if (highCnt[u][l] != 2 && highCnt[u][l] != 5) begin
                            errors++;
                            $display("[TB] FAIL pulse width dut%0d lane%0d: got %0d, expected 2 or 5", u, l, highCnt[u][l]);
                        end
                        acc[u][l] = {acc[u][l][6:0], (highCnt[u][l] >= 4)};
                        nbits[u][l]++;
                        if (nbits[u][l] % 8 == 0) begin
                            if (byteQ[u*2+l].size() == 0) begin
                                checks++; errors++;
                                $display("[TB] FAIL unexpected byte dut%0d lane%0d: got %0h, expected none", u, l, acc[u][l]);
                            end else begin
                                expB = byteQ[u*2+l].pop_front();
                                checkOutput($sformatf("byte dut%0d lane%0d", u, l), int'(acc[u][l]), int'(expB));
                            end
                        end
                    end
                    prevV[u][l] = neo[u][l];
                end
                if (fdS[u]) begin
                    if (frameQ[u].size() == 0) begin
                        checks++; errors++;
                        $display("[TB] FAIL unexpected frameDone dut%0d: got pulse, expected none", u);
                    end else begin
                        fr = frameQ[u].pop_front();
                        checkOutput($sformatf("frame bits dut%0d lane0", u), nbits[u][0], fr.bits);
                        checkOutput($sformatf("frame bits dut%0d lane1", u), nbits[u][1], fr.bits);
                        checkOutput($sformatf("frame length dut%0d", u), cyc - frameStart[u] + 1, fr.len);
                    end
                    nbits[u][0] = 0;
                    nbits[u][1] = 0;
                    frameStart[u] = cyc + 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] addrOf(input int u, input int lane, input int p, input int ch);
        return 5'((lane * 4 + p) * chOf(u) + ch);
    endfunction

    task automatic hwWrite(input int u, input int lane, input int p, input int ch, input logic [7:0] d);
        wrEn[u] = 1'b1; wrAddr[u] = addrOf(u, lane, p, ch); wrData[u] = d;
        tick();
        wrEn[u] = 1'b0;
    endtask

    task automatic writeByte(input int u, input int lane, input int p, input int ch, input logic [7:0] d);
        model[u][lane][p][ch] = d;
        hwWrite(u, lane, p, ch, d);
    endtask

    // Expected content of one frame of n pixels, taken from the model
    task automatic pushFrame(input int u, input int n);
        for (int l = 0; l < 2; l++)
            for (int p = 0; p < n; p++)
                for (int ch = 0; ch < chOf(u); ch++)
                    byteQ[u*2+l].push_back(model[u][l][p][ch]);
        frameQ[u].push_back('{n * chOf(u) * 8, 1 + n * chOf(u) * 64 + 400});
    endtask

    // Start request in the current cycle (cycle 0); returns in cycle 1
    task automatic applyStimulus(input int u, input int cnt);
        pushFrame(u, (cnt > 4) ? 4 : cnt);
        pixelCount[u] = 3'(cnt);
        start[u] = 1'b1;
        tick();
        start[u] = 1'b0;
    endtask

    // Called in cycle 1; returns the first cycle in which busy reads low
    task automatic waitBusyLow(input int u, input int limit, output int c);
        c = 1;
        while (busyS[u] && c < limit) begin
            tick();
            c++;
        end
    endtask

    task automatic waitFrameDone(input int u, input int limit, output int t);
        int n;
        n = 0;
        t = -1;
        while (n < limit && t < 0) begin
            tick();
            n++;
            if (fdS[u]) t = cyc;
        end
    endtask

    int c, t1, t2, extra;

    initial begin
        reset = 1'b1;
        wrEn = '0; start = '0; loop = '0; wrAddr = '0; wrData = '0; pixelCount = '0;
        repeat (3) tick();
        for (int u = 0; u < 2; u++) begin
            checkOutput($sformatf("reset neoData dut%0d", u), int'(neo[u]), 0);
            checkOutput($sformatf("reset busy dut%0d", u), int'(busyS[u]), 0);
            checkOutput($sformatf("reset frameDone dut%0d", u), int'(fdS[u]), 0);
        end
        reset = 1'b0;
        tick();

        // Buffer contents for dut0: lane0 distinct bytes, lane1 all 0xFF
        writeByte(0, 0, 0, 0, 8'h80); writeByte(0, 0, 0, 1, 8'h00); writeByte(0, 0, 0, 2, 8'h01);
        writeByte(0, 0, 1, 0, 8'h11); writeByte(0, 0, 1, 1, 8'h22); writeByte(0, 0, 1, 2, 8'hC3);
        writeByte(0, 0, 2, 0, 8'h44); writeByte(0, 0, 2, 1, 8'h55); writeByte(0, 0, 2, 2, 8'h66);
        writeByte(0, 0, 3, 0, 8'h77); writeByte(0, 0, 3, 1, 8'h88); writeByte(0, 0, 3, 2, 8'hA5);
        for (int p = 0; p < 4; p++)
            for (int ch = 0; ch < 3; ch++)
                writeByte(0, 1, p, ch, 8'hFF);
        // dut1 (RGBW) two pixels per lane
        for (int i = 0; i < 8; i++) begin
            writeByte(1, 0, i / 4, i % 4, 8'(8'h01 + i * 8'h22));
            writeByte(1, 1, i / 4, i % 4, 8'(8'hFE - i * 8'h22));
        end

        // Single pixel frame: 24 bits, 593-cycle frame, busy low in cycle 594
        applyStimulus(0, 1);
        checkOutput("busy after start", int'(busyS[0]), 1);
        waitBusyLow(0, 700, c);
        checkOutput("busy low cycle 1px", c, 594);
        repeat (5) tick();

        // RGBW instance, two pixels: 64 bits per lane
        applyStimulus(1, 2);
        waitBusyLow(1, 1000, c);
        checkOutput("busy low cycle rgbw", c, 914);
        repeat (5) tick();

        // Zero pixels: load then latch only
        applyStimulus(0, 0);
        waitBusyLow(0, 500, c);
        checkOutput("busy low cycle 0px", c, 402);
        repeat (5) tick();

        // Count 7 (largest the 3-bit port carries) clamps to 4 pixels. A
        // late start is ignored. Byte 11 is rewritten long before it is
        // read. Byte 5 is rewritten in the very cycle it is fetched, so
        // its old value is still sent.
        model[0][0][3][2] = 8'h5A;
        applyStimulus(0, 7);
        for (int k = 1; k < 1170; k++) begin
            wrEn[0] = 1'b0;
            start[0] = 1'b0;
            if (k == 100) begin
                wrEn[0] = 1'b1; wrAddr[0] = addrOf(0, 0, 3, 2); wrData[0] = 8'h5A;
            end
            if (k == 200) begin
                start[0] = 1'b1; pixelCount[0] = 3'd1;
            end
            if (k == 321) begin
                wrEn[0] = 1'b1; wrAddr[0] = addrOf(0, 0, 1, 2); wrData[0] = 8'h3C;
            end
            tick();
        end
        wrEn[0] = 1'b0;
        start[0] = 1'b0;
        model[0][0][1][2] = 8'h3C;
        checkOutput("busy low after clamped frame", int'(busyS[0]), 0);
        repeat (5) tick();

        // Looping: two back-to-back frames, loop dropped in the second
        loop[0] = 1'b1;
        applyStimulus(0, 4);
        pushFrame(0, 4);
        waitFrameDone(0, 1300, t1);
        checkOutput("loop first frameDone seen", int'(t1 >= 0), 1);
        repeat (500) tick();
        loop[0] = 1'b0;
        waitFrameDone(0, 1000, t2);
        checkOutput("loop frameDone spacing", t2 - t1, 1169);
        tick();
        checkOutput("busy low after loop stop", int'(busyS[0]), 0);
        extra = 0;
        for (int k = 0; k < 1300; k++) begin
            tick();
            if (fdS[0]) extra++;
        end
        checkOutput("no frameDone after loop stop", extra, 0);

        // Reset in the high phase of the first bit aborts the frame
        applyStimulus(0, 1);
        tick();
        tick();
        checkOutput("high phase before reset", int'(neo[0][0]), 1);
        reset = 1'b1;
        byteQ[0].delete(); byteQ[1].delete(); frameQ[0].delete();
        tick();
        checkOutput("neoData after reset", int'(neo[0]), 0);
        checkOutput("busy after reset", int'(busyS[0]), 0);
        reset = 1'b0;
        applyStimulus(0, 1);
        checkOutput("busy after restart", int'(busyS[0]), 1);
        waitBusyLow(0, 700, c);
        checkOutput("busy low cycle restart", c, 594);
        repeat (5) tick();

        checkOutput("leftover bytes", byteQ[0].size() + byteQ[1].size() + byteQ[2].size() + byteQ[3].size(), 0);
        checkOutput("leftover frames", frameQ[0].size() + frameQ[1].size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
